// File: rtl/ccc_codec_sched.sv
// ---------------------------------------------------------------------------
// ccc_codec_sched
//
// Job controller that sequences the ccc_encoder and ccc_decoder for one frame
// at a time. A request names the job type (encode, decode, or encode-then-
// decode). The controller pulses the matching start strobes and waits for
// each stage's done. It then reports one response pulse carrying a status
// code. Each wait is bounded by TIMEOUT_CYCLES. An abort drops the job.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent in one WAIT state before timing out
//   CNT_W           width of frame_count
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    frame job request
//   req_mode     01 encode, 10 decode, 11 encode then decode, 00 invalid
//   req_ready    high only in IDLE; request accepted on req_valid && req_ready
//   abort        cancel the in-flight job (ignored in IDLE and RESP)
//   enc_start    one-cycle encoder start pulse
//   enc_done     encoder completion, sampled only in ENC_WAIT
//   dec_start    one-cycle decoder start pulse
//   dec_done     decoder completion, sampled only in DEC_WAIT
//   resp_valid   one-cycle job completion pulse
//   resp_status  00 ok, 01 timeout, 10 bad mode, 11 aborted (with resp_valid)
//   busy         high in every state except IDLE
//   frame_count  number of jobs completed with status 00 (wraps)
// ---------------------------------------------------------------------------
module ccc_codec_sched #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [1:0]       req_mode,
    output logic             req_ready,
    input  logic             abort,
    output logic             enc_start,
    input  logic             enc_done,
    output logic             dec_start,
    input  logic             dec_done,
    output logic             resp_valid,
    output logic [1:0]       resp_status,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);

    // The timer only has to reach TIMEOUT_CYCLES-1.
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ENC_START = 3'd1,
        ENC_WAIT  = 3'd2,
        DEC_START = 3'd3,
        DEC_WAIT  = 3'd4,
        RESP      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_TIMEOUT  = 2'b01,
        ST_BAD_MODE = 2'b10,
        ST_ABORT    = 2'b11
    } status_t;

    localparam logic [1:0] MODE_ENC     = 2'b01;
    localparam logic [1:0] MODE_DEC     = 2'b10;
    localparam logic [1:0] MODE_ENC_DEC = 2'b11;

    state_t           state_q, state_d;
    status_t          status_q, status_d;
    logic [1:0]       mode_q, mode_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] frame_count_q;
    logic             in_wait;
    logic             timed_out;

    assign in_wait   = (state_q == ENC_WAIT) || (state_q == DEC_WAIT);
    assign timed_out = (timer_q == TMR_LAST);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        status_d = status_q;
        mode_d   = mode_q;
        // The timer counts only while waiting. Any other state clears it, so
        // each WAIT state starts from zero.
        timer_d  = in_wait ? timer_q + TMR_W'(1) : '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mode_d = req_mode;
                    unique case (req_mode)
                        MODE_ENC, MODE_ENC_DEC: state_d = ENC_START;
                        MODE_DEC:               state_d = DEC_START;
                        default: begin
                            state_d  = RESP;
                            status_d = ST_BAD_MODE;
                        end
                    endcase
                end
            end

            ENC_START: begin
                if (abort) begin
                    state_d  = RESP;
                    status_d = ST_ABORT;
                end else begin
                    state_d = ENC_WAIT;
                end
            end

            // The priority order is abort, then done, then timeout.
            ENC_WAIT: begin
                if (abort) begin
                    state_d  = RESP;
                    status_d = ST_ABORT;
                end else if (enc_done) begin
                    if (mode_q == MODE_ENC_DEC) begin
                        state_d = DEC_START;
                    end else begin
                        state_d  = RESP;
                        status_d = ST_OK;
                    end
                end else if (timed_out) begin
                    state_d  = RESP;
                    status_d = ST_TIMEOUT;
                end
            end

            DEC_START: begin
                if (abort) begin
                    state_d  = RESP;
                    status_d = ST_ABORT;
                end else begin
                    state_d = DEC_WAIT;
                end
            end

            DEC_WAIT: begin
                if (abort) begin
                    state_d  = RESP;
                    status_d = ST_ABORT;
                end else if (dec_done) begin
                    state_d  = RESP;
                    status_d = ST_OK;
                end else if (timed_out) begin
                    state_d  = RESP;
                    status_d = ST_TIMEOUT;
                end
            end

            RESP:    state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= IDLE;
            status_q      <= ST_OK;
            mode_q        <= 2'b00;
            timer_q       <= '0;
            frame_count_q <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            mode_q   <= mode_d;
            timer_q  <= timer_d;
            if (state_q == RESP && status_q == ST_OK) begin
                frame_count_q <= frame_count_q + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // NOTE: the outputs are decoded from state, and rst masks them. The
    // outputs therefore show reset values for the whole time rst is high,
    // including the first cycle before the synchronous reset has taken
    // effect.
    assign req_ready   = !rst && (state_q == IDLE);
    assign busy        = !rst && (state_q != IDLE);
    assign enc_start   = !rst && (state_q == ENC_START) && !abort;
    assign dec_start   = !rst && (state_q == DEC_START) && !abort;
    assign resp_valid  = !rst && (state_q == RESP);
    assign resp_status = resp_valid ? status_q : ST_OK;
    assign frame_count = frame_count_q;

endmodule
